// File: rtl/mem_bank.sv
// Word-addressed memory bank with byte-enable writes and 1-cycle reads.
// Contents are zeroed by a DEPTH-cycle sweep after reset or soft clear.
module mem_bank #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                mode,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic [DATA_W-1:0]   data_out,
  output logic                rd_valid,
  output logic                init_done
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int NB = DATA_W/8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept;
  logic              wr_en;
  logic              rd_en;

  // cnt idles at 0 in RUN, so a clear restarts the sweep from address 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == RUN) cnt <= '0;
      else              cnt <= cnt + ADDR_W'(1);
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      INIT: if (&cnt) state_nx = RUN;
      RUN:  if (clear) state_nx = INIT;
    endcase
  end

  always_comb begin
    req_ready = (state == RUN) && !clear;
    init_done = (state == RUN);
    accept    = req_valid && req_ready;
    wr_en     = accept && !mode;
    rd_en     = accept && mode;
  end

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[cnt] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (byte_en[b]) mem[addr][8*b +: 8] <= data_in[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) data_out <= mem[addr];
    end
  end

endmodule

// File: tb/tb_mem_bank.sv
// Directed bench for mem_bank: sweep timing, byte merge, streaming,
// soft clear and asynchronous reset.
module tb_mem_bank;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        req_valid;
  logic        req_ready;
  logic        mode;
  logic [4:0]  addr;
  logic [63:0] data_in;
  logic [7:0]  byte_en;
  logic [63:0] data_out;
  logic        rd_valid;
  logic        init_done;

  int vectors;
  int miscompares;

  mem_bank dut (
    .clk(clk), .reset(reset), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready),
    .mode(mode), .addr(addr), .data_in(data_in),
    .byte_en(byte_en), .data_out(data_out),
    .rd_valid(rd_valid), .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge where init_done is expected low; counts INIT cycles.
  task automatic wait_init(input string tag, input int clear_at);
    int n = 0;
    while (init_done === 1'b0 && n < 40) begin
      if (n == clear_at) clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      n++;
    end
    vectors++;
    if (n !== 32) begin
      miscompares++;
      $display("FAIL %s_init_cycles: got %0d want 32", tag, n);
    end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_ready: got %b want 1", tag, req_ready);
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [63:0] d,
                          input logic [7:0] be);
    req_valid = 1'b1; mode = 1'b0; addr = a; data_in = d; byte_en = be;
    @(negedge clk);
    req_valid = 1'b0;
    vectors++;
    if (rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_rd_valid a=%0d: got %b want 0", a, rd_valid);
    end
  endtask

  task automatic do_read(input logic [4:0] a, input logic [63:0] exp);
    req_valid = 1'b1; mode = 1'b1; addr = a;
    @(negedge clk);
    req_valid = 1'b0;
    vectors++;
    if (rd_valid !== 1'b1 || data_out !== exp) begin
      miscompares++;
      $display("FAIL rd a=%0d: got v=%b d=%h want v=1 d=%h",
               a, rd_valid, data_out, exp);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (init_done !== 1'b0 || req_ready !== 1'b0 ||
        rd_valid !== 1'b0 || data_out !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got id=%b rr=%b v=%b d=%h want 0",
               init_done, req_ready, rd_valid, data_out);
    end
    reset = 1'b1;
    wait_init("reset", -1);
    for (int i = 0; i < 32; i++) do_read(5'(i), 64'h0);
  endtask

  task automatic test_write_read;
    do_write(5'd3, 64'h00000000_00A5A5A5, 8'hFF);
    do_read(5'd3, 64'h00000000_00A5A5A5);
  endtask

  task automatic test_byte_merge;
    do_write(5'd7, 64'h11223344_55667788, 8'hFF);
    do_write(5'd7, 64'hFFFFFFFF_FFFFFFFF, 8'h0F);
    do_read(5'd7, 64'h11223344_FFFFFFFF);
    do_write(5'd7, 64'h0, 8'h00);
    do_read(5'd7, 64'h11223344_FFFFFFFF);
    do_write(5'd7, 64'hAAAAAAAA_AAAAAAAA, 8'hC0);
    do_read(5'd7, 64'hAAAA3344_FFFFFFFF);
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp [4];
    exp[0] = 64'h0000_0000_0000_1001;
    exp[1] = 64'h0000_0000_0000_2002;
    exp[2] = 64'h0000_0000_0000_3003;
    exp[3] = 64'h00000000_00A5A5A5;
    for (int i = 0; i < 3; i++) do_write(5'(i), exp[i], 8'hFF);
    // unaccepted write must leave addr 1 alone
    req_valid = 1'b0; mode = 1'b0; addr = 5'd1;
    data_in = '1; byte_en = 8'hFF;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; mode = 1'b1; addr = 5'(i);
      @(negedge clk);
      vectors++;
      if (rd_valid !== 1'b1 || data_out !== exp[i]) begin
        miscompares++;
        $display("FAIL stream_%0d: got v=%b d=%h want v=1 d=%h",
                 i, rd_valid, data_out, exp[i]);
      end
    end
    req_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors++;
      if (rd_valid !== 1'b0 || data_out !== exp[3]) begin
        miscompares++;
        $display("FAIL stream_hold_%0d: got v=%b d=%h want v=0 d=%h",
                 k, rd_valid, data_out, exp[3]);
      end
    end
  endtask

  task automatic test_clear;
    logic [63:0] v [10];
    for (int i = 0; i < 10; i++) begin
      v[i] = 64'($urandom & 32'h00FF_FFFF) | 64'h1;
      do_write(5'(i), v[i], 8'hFF);
    end
    do_read(5'd2, v[2]);
    req_valid = 1'b1; mode = 1'b1; addr = 5'd4;
    req_valid = 1'b1; mode = 1'b1; addr = 5'd2;
    @(negedge clk);
    clear = 1'b1; req_valid = 1'b1; mode = 1'b1; addr = 5'd4;
    #1;
    vectors++;
    if (rd_valid !== 1'b1 || req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_ready: got v=%b rr=%b want v=1 rr=0",
               rd_valid, req_ready);
    end
    @(negedge clk);
    clear = 1'b0; req_valid = 1'b0;
    vectors++;
    if (rd_valid !== 1'b0 || init_done !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_accept: got v=%b id=%b want v=0 id=0",
               rd_valid, init_done);
    end
    wait_init("clear", 10);
    for (int i = 0; i < 10; i++) do_read(5'(i), 64'h0);
  endtask

  task automatic test_async_reset;
    do_write(5'd5, 64'hDEADBEEF_01234567, 8'hFF);
    req_valid = 1'b1; mode = 1'b1; addr = 5'd5;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    vectors++;
    if (rd_valid !== 1'b1 || data_out !== 64'hDEADBEEF_01234567) begin
      miscompares++;
      $display("FAIL arst_pre: got v=%b d=%h want v=1 d=deadbeef01234567",
               rd_valid, data_out);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (rd_valid !== 1'b0 || data_out !== 64'h0 || init_done !== 1'b0) begin
      miscompares++;
      $display("FAIL arst_drop: got v=%b d=%h id=%b want all 0",
               rd_valid, data_out, init_done);
    end
    @(negedge clk);
    reset = 1'b1;
    wait_init("arst", -1);
    do_read(5'd5, 64'h0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0; clear = 1'b0; req_valid = 1'b0; mode = 1'b0;
    addr = '0; data_in = '0; byte_en = '0;
    test_reset;
    test_write_read;
    test_byte_merge;
    test_back_to_back;
    test_clear;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
